// File: rtl/rbus_pkg.sv
// rbus_pkg: register-file bus widths, arbiter FSM states and the default idle address
package rbus_pkg;
   localparam int RBUS_AW = 16;
   localparam int RBUS_DW = 16;
   localparam int RBUS_IW = 34;
   localparam logic [RBUS_AW-1:0] RBUS_IDLE_ADDR = 16'hFFFF;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} rbus_state_t;
endpackage

// File: rtl/rbus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, first set req at or above ptr (mod N)
module rr_pick #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] winner,
   output logic                 valid
);
   localparam int PW = $clog2(N);
   logic [PW-1:0] k;
   logic found;
   always_comb begin
      winner = ptr;
      found = 1'b0;
      k = ptr;
      for (int i = 0; i < N; i++) begin
         if (req[k] && !found) begin
            winner = k;
            found = 1'b1;
         end
         k = (k == PW'(N - 1)) ? '0 : k + 1'b1;
      end
      valid = |req;
   end
endmodule

// File: rtl/rbus_arbiter.sv
// rbus_arbiter: round-robin arbiter issuing one register-bus word access per grant.
// Defining RBUS_ARB_LOCK_EN adds a lock input that keeps priority with the current winner.
module rbus_arbiter
   import rbus_pkg::*;
#(
   parameter int                 NREQ      = 2,
   parameter logic [RBUS_AW-1:0] IDLE_ADDR = RBUS_IDLE_ADDR
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ-1:0]           we,
   input  logic [RBUS_AW*NREQ-1:0]   addr,
   input  logic [RBUS_DW*NREQ-1:0]   wrdata,
`ifdef RBUS_ARB_LOCK_EN
   input  logic [NREQ-1:0]           lock,
`endif
   output logic [NREQ-1:0]           gnt,
   output logic [NREQ-1:0]           done,
   output logic [RBUS_DW-1:0]        rddata,
   output logic                      bus_wr,
   output logic [RBUS_AW-1:0]        bus_addr,
   output logic [RBUS_DW-1:0]        bus_wrdata,
   input  logic [RBUS_DW-1:0]        bus_rddata
);
   localparam int PW = $clog2(NREQ);
   rbus_state_t state, state_n;
   logic [PW-1:0] ptr, ptr_n, win, win_n, pick;
   logic [NREQ-1:0] gnt_n, done_n;
   logic [RBUS_DW-1:0] rddata_n, bus_wrdata_n;
   logic [RBUS_AW-1:0] bus_addr_n;
   logic bus_wr_n, valid, hold;

   rr_pick #(.N(NREQ)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (pick),
      .valid  (valid)
   );

`ifdef RBUS_ARB_LOCK_EN
   assign hold = lock[win] & req[win];
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      state_n = state;
      ptr_n = ptr;
      win_n = win;
      gnt_n = gnt;
      done_n = done;
      rddata_n = rddata;
      bus_wr_n = bus_wr;
      bus_addr_n = bus_addr;
      bus_wrdata_n = bus_wrdata;
      case (state)
         IDLE: if (valid) begin
            win_n = pick;
            gnt_n = NREQ'(1) << pick;
            bus_wr_n = we[pick];
            bus_addr_n = addr[RBUS_AW*pick +: RBUS_AW];
            bus_wrdata_n = wrdata[RBUS_DW*pick +: RBUS_DW];
            state_n = ACCESS;
         end
         ACCESS: begin
            rddata_n = bus_rddata;
            bus_wr_n = 1'b0;
            done_n = gnt;
            state_n = DONE;
         end
         DONE: begin
            done_n = '0;
            gnt_n = '0;
            bus_addr_n = IDLE_ADDR;
            ptr_n = hold ? win : (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ptr <= '0;
         win <= '0;
         gnt <= '0;
         done <= '0;
         rddata <= '0;
         bus_wr <= 1'b0;
         bus_addr <= IDLE_ADDR;
         bus_wrdata <= '0;
      end else begin
         state <= state_n;
         ptr <= ptr_n;
         win <= win_n;
         gnt <= gnt_n;
         done <= done_n;
         rddata <= rddata_n;
         bus_wr <= bus_wr_n;
         bus_addr <= bus_addr_n;
         bus_wrdata <= bus_wrdata_n;
      end
   end
endmodule
